// File: rtl/triwave_pkg.sv
// Shared types and default sizes for the triangle/saw PWM generator.
package triwave_pkg;

  typedef enum logic [1:0] {
    MODE_TRI    = 2'b00,
    MODE_SAW_UP = 2'b01,
    MODE_SAW_DN = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  localparam int unsigned DEF_WIDTH       = 8;
  localparam int unsigned DEF_PRE_W       = 16;
  localparam int unsigned DEF_DEAD_CYCLES = 2;

endpackage

// File: rtl/triwave_prescaler.sv
// Tick prescaler: counts 0..prescale and fires tick on the wrap cycle.
module triwave_prescaler #(
  parameter int unsigned PRE_W = 16
) (
  input  logic             sysclk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [PRE_W-1:0] prescale,
  output logic             tick
);

  logic [PRE_W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = !clr && (cnt_q == prescale);
    cnt_d = cnt_q + PRE_W'(1);
    if (clr || tick) cnt_d = '0;
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/triwave_pwm_generator.sv
// Multi-mode wave generator with shadowed settings and registered PWM compare.
// Define TRIWAVE_DEADTIME_EN to add complementary Pulse_n with dead-time insertion.
module triwave_pwm_generator
  import triwave_pkg::*;
#(
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned PRE_W       = DEF_PRE_W,
  parameter int unsigned DEAD_CYCLES = DEF_DEAD_CYCLES
) (
  input  logic             sysclk,
  input  logic             rst_n,
  input  logic             Enable_SW,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] peak,
  input  logic [WIDTH-1:0] step,
  input  logic [PRE_W-1:0] prescale,
  input  logic [WIDTH-1:0] duty,
  output logic [WIDTH-1:0] wave,
  output logic             Pulse,
  output logic             dir,
  output logic             period_start
`ifdef TRIWAVE_DEADTIME_EN
  ,
  output logic             Pulse_n
`endif
);

  logic             en_q;
  logic [WIDTH-1:0] wave_q, wave_d;
  logic             dir_q, dir_d;
  logic             ps_q, ps_d;
  logic             pulse_q, pulse_d;
  logic [WIDTH-1:0] hold_cnt_q, hold_cnt_d;
  mode_e            mode_sh_q;
  logic [WIDTH-1:0] peak_sh_q, step_sh_q, duty_sh_q;
  logic [PRE_W-1:0] pre_sh_q;
  logic [WIDTH-1:0] step_eff;
  logic [WIDTH:0]   sum;
  logic             tick;

  triwave_prescaler #(.PRE_W(PRE_W)) u_prescaler (
    .sysclk   (sysclk),
    .rst_n    (rst_n),
    .clr      (!Enable_SW || !en_q),
    .prescale (pre_sh_q),
    .tick     (tick)
  );

  always_comb begin
    step_eff   = (step_sh_q == '0) ? WIDTH'(1) : step_sh_q;
    sum        = {1'b0, wave_q} + {1'b0, step_eff};
    wave_d     = wave_q;
    dir_d      = dir_q;
    ps_d       = 1'b0;
    hold_cnt_d = hold_cnt_q;
    if (!Enable_SW) begin
      wave_d     = '0;
      dir_d      = 1'b1;
      hold_cnt_d = '0;
    end else if (!en_q) begin
      ps_d   = 1'b1;
      wave_d = (mode == MODE_SAW_DN) ? peak : '0;
      dir_d  = (mode != MODE_SAW_DN);
    end else if (tick) begin
      case (mode_sh_q)
        MODE_TRI: begin
          // peak=0 collapses the period to a single tick
          if (peak_sh_q == '0) begin
            wave_d = '0;
            dir_d  = 1'b1;
            ps_d   = 1'b1;
          end else if (dir_q) begin
            if (sum >= {1'b0, peak_sh_q}) begin
              wave_d = peak_sh_q;
              dir_d  = 1'b0;
            end else begin
              wave_d = sum[WIDTH-1:0];
            end
          end else if (wave_q <= step_eff) begin
            wave_d = '0;
            dir_d  = 1'b1;
            ps_d   = 1'b1;
          end else begin
            wave_d = wave_q - step_eff;
          end
        end
        MODE_SAW_UP: begin
          dir_d = 1'b1;
          if (sum > {1'b0, peak_sh_q}) begin
            wave_d = '0;
            ps_d   = 1'b1;
          end else begin
            wave_d = sum[WIDTH-1:0];
          end
        end
        MODE_SAW_DN: begin
          dir_d = 1'b0;
          if (wave_q < step_eff) begin
            wave_d = peak_sh_q;
            ps_d   = 1'b1;
          end else begin
            wave_d = wave_q - step_eff;
          end
        end
        default: begin
          hold_cnt_d = hold_cnt_q + WIDTH'(1);
          ps_d       = (hold_cnt_q == '1);
        end
      endcase
    end
    if (ps_d) hold_cnt_d = '0;
  end

`ifdef TRIWAVE_DEADTIME_EN
  localparam int unsigned DT_W = $clog2(DEAD_CYCLES + 1) + 1;

  logic            raw, raw_q, settled;
  logic            pulse_n_q, pulse_n_d;
  logic [DT_W-1:0] dt_cnt_q, dt_cnt_d;

  // Either output may rise only once the compare has held for DEAD_CYCLES edges.
  always_comb begin
    raw       = (wave_q < duty_sh_q);
    settled   = (raw == raw_q) && (dt_cnt_q >= DT_W'(DEAD_CYCLES));
    pulse_d   = Enable_SW && raw && settled;
    pulse_n_d = Enable_SW && !raw && settled;
    if (!Enable_SW || (raw != raw_q)) dt_cnt_d = '0;
    else if (dt_cnt_q < DT_W'(DEAD_CYCLES)) dt_cnt_d = dt_cnt_q + DT_W'(1);
    else dt_cnt_d = dt_cnt_q;
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      raw_q     <= 1'b0;
      dt_cnt_q  <= '0;
      pulse_n_q <= 1'b0;
    end else begin
      raw_q     <= raw;
      dt_cnt_q  <= dt_cnt_d;
      pulse_n_q <= pulse_n_d;
    end
  end

  assign Pulse_n = pulse_n_q;
`else
  always_comb begin
    pulse_d = Enable_SW && (wave_q < duty_sh_q);
  end
`endif

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      en_q       <= 1'b0;
      wave_q     <= '0;
      dir_q      <= 1'b1;
      ps_q       <= 1'b0;
      pulse_q    <= 1'b0;
      hold_cnt_q <= '0;
      mode_sh_q  <= MODE_TRI;
      peak_sh_q  <= '0;
      step_sh_q  <= '0;
      duty_sh_q  <= '0;
      pre_sh_q   <= '0;
    end else begin
      en_q       <= Enable_SW;
      wave_q     <= wave_d;
      dir_q      <= dir_d;
      ps_q       <= ps_d;
      pulse_q    <= pulse_d;
      hold_cnt_q <= hold_cnt_d;
      if (ps_d) begin
        mode_sh_q <= mode_e'(mode);
        peak_sh_q <= peak;
        step_sh_q <= step;
        duty_sh_q <= duty;
        pre_sh_q  <= prescale;
      end
    end
  end

  assign wave         = wave_q;
  assign Pulse        = pulse_q;
  assign dir          = dir_q;
  assign period_start = ps_q;

endmodule

// File: doc/triwave_pwm_generator.md
Name: triwave_pwm_generator

Overview:
- Parametrised successor to the single-mode triangle/pulse generator.
- Produces a programmable-width waveform sample from one of four modes: triangle, saw-up, saw-down or hold.
- Also produces a registered PWM `Pulse` by comparing the wave against a duty value.
- Sits between the switch/config logic and the output pins or DAC; all runtime settings are shadowed and take effect only at period boundaries.

Parameters:
- WIDTH, 8: bit width of wave, peak, step and duty.
- PRE_W, 16: width of the prescale field.
- DEAD_CYCLES, 2: dead-time length in sysclk cycles; used only with TRIWAVE_DEADTIME_EN.

Ports:
- sysclk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- Enable_SW  in  1  run enable; level-sensitive.
- mode  in  2  waveform select: 00 triangle, 01 saw-up, 10 saw-down, 11 hold.
- peak  in  WIDTH  top value of the wave.
- step  in  WIDTH  amount added or subtracted per tick; 0 is treated as 1.
- prescale  in  PRE_W  one tick every prescale+1 sysclk cycles.
- duty  in  WIDTH  compare value; Pulse=1 while wave < duty.
- wave  out  WIDTH  current sample.
- Pulse  out  1  PWM output.
- dir  out  1  1 = counting up, 0 = counting down.
- period_start  out  1  one-cycle strobe at the start of each period.

Behaviour:
- Reset (rst_n=0, asynchronous): wave=0, dir=1, Pulse=0, period_start=0, prescale counter=0, all shadow registers=0.
- Disabled (Enable_SW=0):
  - wave=0, dir=1, Pulse=0, prescale counter=0; shadows hold.
  - Dropping Enable_SW mid-period forces these values on the next edge.
- Enable rising, first enabled cycle:
  - Load shadows from mode, peak, step, duty and prescale.
  - Assert period_start; wave stays 0.
  - For saw-down only, wave loads peak instead.
- Tick: prescale counter counts 0..prescale_sh and wraps. A tick fires on the wrap cycle, so prescale=0 means a tick every cycle.
- On each tick, all arithmetic is done in WIDTH+1 bits so nothing overflows:
  - Triangle, dir=1: if wave+step >= peak, then wave=peak and dir=0; else wave += step.
  - Triangle, dir=0: if wave <= step, then wave=0, dir=1 and period_start=1; else wave -= step.
  - Saw-up: if wave+step > peak, then wave=0 and period_start=1; else wave += step. dir is held at 1.
  - Saw-down: if wave < step, then wave=peak and period_start=1; else wave -= step. dir is held at 0.
  - Hold: wave is frozen. period_start fires every 2^WIDTH ticks so shadows can still reload.
- Shadow reload: on the same edge that asserts period_start, all shadows reload from the inputs. The reloaded values govern the next tick. A mid-period input change has no effect until then.
- Pulse: registered as (wave < duty_sh) using the current wave, so it lags wave by 1 cycle.
  - duty=0 gives Pulse always 0.
  - duty > peak gives Pulse always 1 while enabled.
- peak=0: wave stays 0 and period_start fires every tick.
- step >= peak (triangle): the wave alternates 0 and peak.
- period_start is high for exactly 1 cycle per event and is never asserted when disabled.

Optional Feature:
- Macro: TRIWAVE_DEADTIME_EN.
- With the macro:
  - Adds output Pulse_n (1 bit, reset 0).
  - Raw compare r = (wave < duty_sh).
  - Pulse follows r and Pulse_n follows ~r, but each output goes high only after r has been stable for DEAD_CYCLES cycles. Turn-off is immediate.
  - Pulse and Pulse_n are never high together.
  - When disabled, both are 0.
- Without the macro: no Pulse_n port; Pulse behaves exactly as in Behaviour.

Decomposition:
- Package triwave_pkg holds:
  - MODE_TRI=2'b00, MODE_SAW_UP=2'b01, MODE_SAW_DN=2'b10, MODE_HOLD=2'b11, as a 2-bit mode typedef.
  - Default-width localparams.
- Sub-module triwave_prescaler (PRE_W): inputs sysclk, rst_n, clr, prescale; output tick.
- Dead-time logic stays inline under the macro.

Test Plan:
- WIDTH=8, triangle, peak=4, step=1, prescale=0, duty=2, enable at cycle 0 -> wave 0,1,2,3,4,3,2,1,0,1…; period_start at enable and every 8 ticks; Pulse high on the cycle after each wave of 0 or 1.
- Saw-up, peak=10, step=3, prescale=1 -> wave 0,3,6,9,0 with changes every 2 cycles; period_start on each wrap to 0.
- Saw-down, peak=7, step=2 -> wave 7,5,3,1,7; change duty to 0 mid-period -> Pulse unchanged until the next period_start, then 0.
- Drop Enable_SW at wave=3 -> next edge wave=0, Pulse=0, no period_start; re-enable -> period_start, fresh shadow load.
- Assert rst_n=0 asynchronously between edges mid-run -> outputs go to reset values immediately, without waiting for a clock edge.
- With TRIWAVE_DEADTIME_EN, DEAD_CYCLES=2, triangle peak=4 duty=2 -> every Pulse/Pulse_n transition has ≥2 cycles with both low; never both high.
